// File: rtl/lcd_reader_if.sv
// Request/response handshake between a host controller and the HD44780 read engine.
interface lcd_reader_if;
  logic       start;
  logic       rs_in;
  logic       poll_in;
  logic       busy;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       bf_timeout;

  modport master (
    output start, rs_in, poll_in,
    input  busy, rd_valid, rd_data, bf_timeout
  );

  modport slave (
    input  start, rs_in, poll_in,
    output busy, rd_valid, rd_data, bf_timeout
  );
endinterface

// File: rtl/lcd_reader.sv
// 4-bit HD44780 read engine: two nibble reads per byte, with optional busy-flag polling.
module lcd_reader #(
  parameter int unsigned T_AS     = 2,
  parameter int unsigned E_HIGH   = 6,
  parameter int unsigned E_LOW    = 6,
  parameter int unsigned POLL_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  lcd_reader_if.slave      bus,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_en,
  output logic             lcd_data_oe,
  input  logic [3:0]       lcd_data_in
);

  localparam int unsigned CNT_MAX = (T_AS > E_HIGH) ? ((T_AS > E_LOW) ? T_AS : E_LOW)
                                                    : ((E_HIGH > E_LOW) ? E_HIGH : E_LOW);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ATT_W   = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, EN_LO, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic               nib_q, nib_d;
  logic               poll_q, poll_d;
  logic               rs_sel_q, rs_sel_d;
  logic [7:0]         shadow_q, shadow_d;
  logic [3:0]         din_q;
  logic               busy_q, busy_d;
  logic               rd_valid_q, rd_valid_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               bf_timeout_q, bf_timeout_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic               lcd_rw_q, lcd_rw_d;
  logic               lcd_en_q, lcd_en_d;
  logic               lcd_oe_q, lcd_oe_d;
  logic               finish;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    att_d        = att_q;
    nib_d        = nib_q;
    poll_d       = poll_q;
    rs_sel_d     = rs_sel_q;
    shadow_d     = shadow_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    bf_timeout_d = 1'b0;
    finish       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          poll_d   = bus.poll_in;
          rs_sel_d = bus.poll_in ? 1'b0 : bus.rs_in;
          nib_d    = 1'b0;
          att_d    = ATT_W'(1);
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(T_AS - 1)) begin
          cnt_d   = '0;
          state_d = EN_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EN_HI: begin
        if (cnt_q == CNT_W'(E_HIGH - 1)) begin
          if (nib_q) shadow_d[3:0] = din_q;
          else       shadow_d[7:4] = din_q;
          cnt_d   = '0;
          state_d = EN_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EN_LO: begin
        if (cnt_q == CNT_W'(E_LOW - 1)) begin
          cnt_d = '0;
          if (!nib_q) begin
            nib_d   = 1'b1;
            state_d = EN_HI;
          end else begin
            state_d = DONE;
            // Outcome is decided on entry so rd_valid lands in the DONE cycle itself.
            finish  = !poll_q || !shadow_q[7] || (att_q == ATT_W'(POLL_MAX));
            if (finish) begin
              rd_valid_d   = 1'b1;
              rd_data_d    = shadow_q;
              bf_timeout_d = poll_q && shadow_q[7];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (rd_valid_q) begin
          state_d = IDLE;
        end else begin
          att_d   = att_q + 1'b1;
          nib_d   = 1'b0;
          state_d = SETUP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin outputs are registered from the next state so they align with state_q.
    busy_d   = (state_d != IDLE);
    lcd_oe_d = (state_d == IDLE);
    lcd_rw_d = (state_d == SETUP) || (state_d == EN_HI) || (state_d == EN_LO);
    lcd_en_d = (state_d == EN_HI);
    lcd_rs_d = (state_d != IDLE) ? rs_sel_d : 1'b0;
  end

  always_ff @(posedge clk) begin
    din_q <= lcd_data_in;
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      att_q        <= '0;
      nib_q        <= 1'b0;
      poll_q       <= 1'b0;
      rs_sel_q     <= 1'b0;
      shadow_q     <= '0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      bf_timeout_q <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_rw_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
      lcd_oe_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      att_q        <= att_d;
      nib_q        <= nib_d;
      poll_q       <= poll_d;
      rs_sel_q     <= rs_sel_d;
      shadow_q     <= shadow_d;
      busy_q       <= busy_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      bf_timeout_q <= bf_timeout_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_rw_q     <= lcd_rw_d;
      lcd_en_q     <= lcd_en_d;
      lcd_oe_q     <= lcd_oe_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.bf_timeout = bf_timeout_q;
  assign lcd_rs         = lcd_rs_q;
  assign lcd_rw         = lcd_rw_q;
  assign lcd_en         = lcd_en_q;
  assign lcd_data_oe    = lcd_oe_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Randomized self-checking bench for lcd_reader with a behavioural HD44780 read-side model.
module tb_lcd_reader;
  localparam int T_AS = 2, E_HIGH = 6, E_LOW = 6, POLL_MAX = 4;
  localparam int RD_LAT = 1 + T_AS + 2 * (E_HIGH + E_LOW);

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_data_oe;
  logic [3:0] lcd_data_in;

  lcd_reader_if bus();

  lcd_reader #(.T_AS(T_AS), .E_HIGH(E_HIGH), .E_LOW(E_LOW), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data_oe(lcd_data_oe), .lcd_data_in(lcd_data_in)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  // LCD model: byte k of rsp answers the k-th read; E falling edges advance the nibble.
  logic [7:0] rsp [8];
  int         rsp_n = 1;
  int         epulse = 0;
  int         base = 0;
  logic       en_prev = 1'b0;

  always @(negedge clk) begin
    en_prev <= lcd_en;
    if (en_prev && !lcd_en) epulse <= epulse + 1;
  end

  always_comb begin
    int p;
    int i;
    logic [7:0] b;
    p = epulse - base;
    i = p / 2;
    if (i >= rsp_n) i = rsp_n - 1;
    if (i < 0) i = 0;
    b = rsp[i];
    lcd_data_in = (p % 2 == 0) ? b[7:4] : b[3:0];
    if (!lcd_en) lcd_data_in = ~lcd_data_in;
  end

  // Expected result of one request, from the read/poll rules.
  function automatic void model(input logic poll, output int reads, output logic [7:0] d,
                                output logic to);
    logic [7:0] b;
    reads = 1; d = rsp[0]; to = 1'b0;
    if (poll) begin
      reads = POLL_MAX; to = 1'b1;
      for (int k = 0; k < POLL_MAX; k++) begin
        b = rsp[(k < rsp_n) ? k : rsp_n - 1];
        if (!b[7]) begin reads = k + 1; to = 1'b0; break; end
      end
      b = rsp[(reads - 1 < rsp_n) ? reads - 1 : rsp_n - 1];
      d = b;
    end
  endfunction

  // Issues one request (caller is #1 after a posedge with busy=0) and records what happened.
  task automatic run_read(input logic poll, input logic rs, input int ign1, input int ign2,
                          output int vcyc, output int nvalid, output int ecyc,
                          output int en_cyc, output int npulse, output int viol,
                          output logic bf, output logic [7:0] data,
                          output logic rs_bad, output logic hold_bad);
    logic [7:0] prev_data;
    logic prev_en, prev_rw;
    vcyc = -1; nvalid = 0; ecyc = -1; en_cyc = 0; npulse = 0; viol = 0;
    bf = 1'b0; data = bus.rd_data; rs_bad = 1'b0; hold_bad = 1'b0;
    prev_data = bus.rd_data; prev_en = lcd_en; prev_rw = lcd_rw;
    base = epulse;
    bus.start = 1'b1; bus.poll_in = poll; bus.rs_in = rs;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(posedge clk); #1;
      bus.start = (cyc == ign1) || (cyc == ign2);
      if (bus.start) begin
        bus.poll_in = 1'($urandom);
        bus.rs_in   = 1'($urandom);
      end
      if (lcd_en) en_cyc++;
      if (lcd_en && !prev_en) npulse++;
      if (lcd_en && !lcd_rw) viol++;
      if (prev_en && lcd_en && (lcd_rw !== prev_rw)) viol++;
      if (lcd_rw && lcd_data_oe) viol++;
      if (bus.bf_timeout && !bus.rd_valid) viol++;
      if (lcd_rw && (lcd_rs !== (poll ? 1'b0 : rs))) rs_bad = 1'b1;
      if (bus.rd_valid) begin
        nvalid++; vcyc = cyc; data = bus.rd_data; bf = bus.bf_timeout;
      end else if (bus.rd_data !== prev_data) begin
        hold_bad = 1'b1;
      end
      prev_data = bus.rd_data; prev_en = lcd_en; prev_rw = lcd_rw;
      if (!bus.busy) begin ecyc = cyc; break; end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.rs_in = 1'b0; bus.poll_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk++;
    if ({bus.busy, bus.rd_valid, bus.rd_data, bus.bf_timeout, lcd_rs, lcd_rw, lcd_en, lcd_data_oe}
        !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      err++;
      $display("FAIL reset_values got busy=%b vld=%b data=%h bf=%b rs=%b rw=%b en=%b oe=%b exp 0 0 00 0 0 0 0 1",
               bus.busy, bus.rd_valid, bus.rd_data, bus.bf_timeout, lcd_rs, lcd_rw, lcd_en, lcd_data_oe);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk++;
      if ({bus.rd_valid, lcd_data_oe, lcd_rw, lcd_en, lcd_rs, bus.busy} !== 6'b010000) begin
        err++;
        $display("FAIL idle_cycle%0d got vld/oe/rw/en/rs/busy=%b exp 010000", c,
                 {bus.rd_valid, lcd_data_oe, lcd_rw, lcd_en, lcd_rs, bus.busy});
      end
    end
  endtask

  task automatic test_reset_abort();
    int nvalid = 0;
    rsp[0] = 8'hA5; rsp_n = 1; base = epulse;
    bus.start = 1'b1; bus.poll_in = 1'b0; bus.rs_in = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.rd_valid) nvalid++;
    end
    chk++;
    if (lcd_en !== 1'b1) begin
      err++; $display("FAIL abort_en_before got=%b exp=1", lcd_en);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk++;
    if ({bus.busy, bus.rd_valid, bus.rd_data, bus.bf_timeout, lcd_rs, lcd_rw, lcd_en, lcd_data_oe}
        !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      err++;
      $display("FAIL abort_reset_values got busy=%b vld=%b data=%h rs=%b rw=%b en=%b oe=%b exp 0 0 00 0 0 0 1",
               bus.busy, bus.rd_valid, bus.rd_data, lcd_rs, lcd_rw, lcd_en, lcd_data_oe);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.rd_valid || bus.busy) nvalid++;
    end
    chk++;
    if (nvalid != 0 || bus.rd_data !== 8'h00) begin
      err++; $display("FAIL abort_no_valid got valid/busy=%0d data=%h exp 0 00", nvalid, bus.rd_data);
    end
  endtask

  task automatic test_single();
    int vcyc, nvalid, ecyc, en_cyc, npulse, viol;
    logic bf, rs_bad, hold_bad;
    logic [7:0] data;
    rsp[0] = 8'hA5; rsp_n = 1;
    run_read(1'b0, 1'b1, -1, -1, vcyc, nvalid, ecyc, en_cyc, npulse, viol, bf, data, rs_bad, hold_bad);
    chk++; if (vcyc != RD_LAT || nvalid != 1) begin
      err++; $display("FAIL single_latency got=%0d n=%0d exp=%0d n=1", vcyc, nvalid, RD_LAT); end
    chk++; if (data !== 8'hA5 || bf !== 1'b0) begin
      err++; $display("FAIL single_data got=%h bf=%b exp=a5 bf=0", data, bf); end
    chk++; if (en_cyc != 2 * E_HIGH || npulse != 2) begin
      err++; $display("FAIL single_en got cycles=%0d pulses=%0d exp %0d 2", en_cyc, npulse, 2 * E_HIGH); end
    chk++; if (rs_bad || viol != 0 || hold_bad) begin
      err++; $display("FAIL single_pins got rs_bad=%b viol=%0d hold_bad=%b exp 0 0 0", rs_bad, viol, hold_bad); end
    chk++; if (ecyc != RD_LAT + 1 || lcd_data_oe !== 1'b1) begin
      err++; $display("FAIL single_release got idle_cyc=%0d oe=%b exp %0d 1", ecyc, lcd_data_oe, RD_LAT + 1); end
  endtask

  task automatic test_poll();
    int vcyc, nvalid, ecyc, en_cyc, npulse, viol;
    logic bf, rs_bad, hold_bad;
    logic [7:0] data;
    rsp[0] = 8'h80; rsp[1] = 8'h80; rsp[2] = 8'h12; rsp_n = 3;
    run_read(1'b1, 1'b1, -1, -1, vcyc, nvalid, ecyc, en_cyc, npulse, viol, bf, data, rs_bad, hold_bad);
    chk++; if (vcyc != 3 * RD_LAT || nvalid != 1) begin
      err++; $display("FAIL poll_latency got=%0d n=%0d exp=%0d n=1", vcyc, nvalid, 3 * RD_LAT); end
    chk++; if (data !== 8'h12 || bf !== 1'b0 || npulse != 6) begin
      err++; $display("FAIL poll_data got=%h bf=%b pulses=%0d exp=12 bf=0 pulses=6", data, bf, npulse); end
    chk++; if (rs_bad || viol != 0 || hold_bad) begin
      err++; $display("FAIL poll_pins got rs_bad=%b viol=%0d hold_bad=%b exp 0 0 0", rs_bad, viol, hold_bad); end
  endtask

  task automatic test_timeout();
    int vcyc, nvalid, ecyc, en_cyc, npulse, viol;
    logic bf, rs_bad, hold_bad;
    logic [7:0] data;
    rsp[0] = 8'h8F; rsp_n = 1;
    run_read(1'b1, 1'b0, -1, -1, vcyc, nvalid, ecyc, en_cyc, npulse, viol, bf, data, rs_bad, hold_bad);
    chk++; if (vcyc != POLL_MAX * RD_LAT || nvalid != 1 || bf !== 1'b1) begin
      err++; $display("FAIL timeout_pulse got cyc=%0d n=%0d bf=%b exp %0d 1 1", vcyc, nvalid, bf, POLL_MAX * RD_LAT); end
    chk++; if (data !== 8'h8F || ecyc != vcyc + 1) begin
      err++; $display("FAIL timeout_data got=%h idle_cyc=%0d exp=8f %0d", data, ecyc, vcyc + 1); end
  endtask

  task automatic test_ignore_start();
    int vcyc, nvalid, ecyc, en_cyc, npulse, viol;
    logic bf, rs_bad, hold_bad;
    logic [7:0] data, exp_d;
    exp_d = 8'($urandom); rsp[0] = exp_d; rsp_n = 1;
    run_read(1'b0, 1'b0, 5, 15, vcyc, nvalid, ecyc, en_cyc, npulse, viol, bf, data, rs_bad, hold_bad);
    chk++; if (nvalid != 1 || vcyc != RD_LAT || data !== exp_d || ecyc != RD_LAT + 1 || npulse != 2) begin
      err++; $display("FAIL ignore_start got n=%0d cyc=%0d data=%h pulses=%0d exp 1 %0d %h 2",
                      nvalid, vcyc, data, npulse, RD_LAT, exp_d); end
    exp_d = 8'($urandom); rsp[0] = exp_d;
    run_read(1'b0, 1'b1, -1, -1, vcyc, nvalid, ecyc, en_cyc, npulse, viol, bf, data, rs_bad, hold_bad);
    chk++; if (nvalid != 1 || vcyc != RD_LAT || data !== exp_d || rs_bad || viol != 0) begin
      err++; $display("FAIL after_ignore got n=%0d cyc=%0d data=%h rs_bad=%b viol=%0d exp 1 %0d %h 0 0",
                      nvalid, vcyc, data, rs_bad, viol, RD_LAT, exp_d); end
  endtask

  task automatic test_random();
    int vcyc, nvalid, ecyc, en_cyc, npulse, viol, reads;
    logic bf, rs_bad, hold_bad, poll, rs, exp_to;
    logic [7:0] data, exp_d;
    for (int it = 0; it < 25; it++) begin
      poll = 1'($urandom); rs = 1'($urandom);
      rsp_n = $urandom_range(1, 6);
      for (int k = 0; k < 8; k++) begin
        rsp[k] = 8'($urandom);
        rsp[k][7] = ($urandom_range(0, 3) != 0);
      end
      model(poll, reads, exp_d, exp_to);
      run_read(poll, rs, -1, -1, vcyc, nvalid, ecyc, en_cyc, npulse, viol, bf, data, rs_bad, hold_bad);
      chk++;
      if (vcyc != reads * RD_LAT || nvalid != 1 || data !== exp_d || bf !== exp_to ||
          npulse != 2 * reads || en_cyc != 2 * E_HIGH * reads || rs_bad || viol != 0 || hold_bad ||
          ecyc != vcyc + 1) begin
        err++;
        $display("FAIL random%0d got cyc=%0d n=%0d data=%h bf=%b pulses=%0d viol=%0d rs_bad=%b hold=%b exp cyc=%0d data=%h bf=%b pulses=%0d",
                 it, vcyc, nvalid, data, bf, npulse, viol, rs_bad, hold_bad,
                 reads * RD_LAT, exp_d, exp_to, 2 * reads);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) rsp[k] = 8'h00;
    test_reset();
    test_reset_abort();
    test_single();
    test_poll();
    test_timeout();
    test_ignore_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
